// File: rtl/loop_bank_sequencer.sv
// loop_bank_sequencer
//   Multi-bank loop sequencer between the audio sample path and an
//   SRAM-style RAM port. Each sample_tick starts one sweep over all banks.
//   For every bank it may play (timed read, mixed into an accumulator),
//   record (timed write of the latched sample), or both (read first).
//   The word address is {block, bank}, so each block owns NBANKS
//   consecutive words. At the end of each sweep it publishes the mix and
//   updates the active-bank mask, the loop length and the block counter.
//
// Ports
//   clk_100MHz, rstn          clock, async active-low reset
//   sample_tick, sample_in    sweep start strobe, sample to record
//   play_en, rec_en, rec_bank play / record controls (rec_* latched on tick)
//   del_req, del_bank, del_ack bank delete request / completion pulse
//   ram_a, ram_dq_i, ram_dq_o RAM address, write data, read data
//   ram_cen/oen/wen           active-low RAM strobes
//   mix_out, mix_valid        summed played banks, one-cycle update pulse
//   active, block, max_block  bank mask, current block, loop length (0 = none)
//   busy, overrun             sweep in progress, sticky tick-while-busy flag
module loop_bank_sequencer #(
  parameter int NBANKS    = 8,
  parameter int BANK_BITS = 3,
  parameter int BLOCK_W   = 23,
  parameter int DATA_W    = 32,
  parameter int ACC_CYC   = 27
) (
  input  logic                         clk_100MHz,
  input  logic                         rstn,
  input  logic                         sample_tick,
  input  logic [DATA_W-1:0]            sample_in,
  input  logic                         play_en,
  input  logic                         rec_en,
  input  logic [BANK_BITS-1:0]         rec_bank,
  input  logic                         del_req,
  input  logic [BANK_BITS-1:0]         del_bank,
  output logic                         del_ack,
  output logic [BANK_BITS+BLOCK_W-1:0] ram_a,
  output logic [DATA_W-1:0]            ram_dq_i,
  input  logic [DATA_W-1:0]            ram_dq_o,
  output logic                         ram_cen,
  output logic                         ram_oen,
  output logic                         ram_wen,
  output logic [DATA_W+BANK_BITS-1:0]  mix_out,
  output logic                         mix_valid,
  output logic [NBANKS-1:0]            active,
  output logic [BLOCK_W-1:0]           block,
  output logic [BLOCK_W-1:0]           max_block,
  output logic                         busy,
  output logic                         overrun
);

  localparam int CNT_W = $clog2(ACC_CYC) + 1;
  localparam int ACC_W = DATA_W + BANK_BITS;
  localparam logic [BLOCK_W-1:0] BLK_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_DECIDE, S_READ, S_WRITE, S_RECOV, S_NEXT, S_FINISH
  } state_t;

  state_t r_state, w_state_nxt;

  logic [BANK_BITS-1:0] r_bank;
  logic [ACC_W-1:0]     r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_rec_en_l;
  logic [BANK_BITS-1:0] r_rec_bank_l;
  logic                 r_del_pend;
  logic [BANK_BITS-1:0] r_del_bank_l;
  logic                 r_wr;        // write decision for the current bank
  logic                 r_from_rd;   // RECOV follows a read (write may follow)
  logic                 r_wr_fired;  // a write was issued this sweep
  logic                 r_rec_seen;  // recorded while loop length undefined

  logic                 w_rd, w_wr, w_last;
  logic [BANK_BITS-1:0] w_bank_inc;
  logic [BLOCK_W-1:0]   w_blk_inc;
  logic [NBANKS-1:0]    w_set, w_clr, w_active_nxt;

  // A pending delete of the bank being recorded suppresses the write, so
  // the delete wins and the bank never becomes active.
  always_comb begin
    w_rd       = play_en & active[r_bank];
    w_wr       = r_rec_en_l & (r_rec_bank_l == r_bank) &
                 ~(r_del_pend & (r_del_bank_l == r_bank));
    w_last     = (r_cnt == CNT_W'(ACC_CYC - 1));
    w_bank_inc = r_bank + BANK_BITS'(1);
    w_blk_inc  = block + BLOCK_W'(1);
    w_set      = r_wr_fired ? (NBANKS'(1) << r_rec_bank_l) : '0;
    w_clr      = r_del_pend ? (NBANKS'(1) << r_del_bank_l) : '0;
    w_active_nxt = (active | w_set) & ~w_clr;
  end

  always_ff @(posedge clk_100MHz or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (sample_tick) w_state_nxt = S_DECIDE;
      S_DECIDE: begin
        if (w_rd)      w_state_nxt = S_READ;
        else if (w_wr) w_state_nxt = S_WRITE;
        else           w_state_nxt = S_NEXT;
      end
      S_READ:   if (w_last) w_state_nxt = S_RECOV;
      S_WRITE:  if (w_last) w_state_nxt = S_RECOV;
      S_RECOV:  w_state_nxt = (r_from_rd & r_wr) ? S_WRITE : S_NEXT;
      S_NEXT:   w_state_nxt = (r_bank == BANK_BITS'(NBANKS - 1)) ? S_FINISH : S_DECIDE;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered outputs. ram_a is loaded whenever the bank
  // index changes, i.e. while entering DECIDE, so it is stable one cycle
  // before any strobe falls and holds through RECOV.
  always_ff @(posedge clk_100MHz or negedge rstn) begin
    if (!rstn) begin
      r_bank       <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_rec_en_l   <= 1'b0;
      r_rec_bank_l <= '0;
      r_del_pend   <= 1'b0;
      r_del_bank_l <= '0;
      r_wr         <= 1'b0;
      r_from_rd    <= 1'b0;
      r_wr_fired   <= 1'b0;
      r_rec_seen   <= 1'b0;
      ram_a        <= '0;
      ram_dq_i     <= '0;
      ram_cen      <= 1'b1;
      ram_oen      <= 1'b1;
      ram_wen      <= 1'b1;
      mix_out      <= '0;
      mix_valid    <= 1'b0;
      del_ack      <= 1'b0;
      active       <= '0;
      block        <= '0;
      max_block    <= '0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      del_ack   <= 1'b0;

      if (sample_tick && busy) overrun <= 1'b1;

      // A new request overrides the one being retired in FINISH.
      if (del_req) begin
        r_del_pend   <= 1'b1;
        r_del_bank_l <= del_bank;
      end else if (r_state == S_FINISH) begin
        r_del_pend   <= 1'b0;
      end

      case (r_state)
        S_IDLE: if (sample_tick) begin
          ram_dq_i     <= sample_in;
          r_rec_en_l   <= rec_en;
          r_rec_bank_l <= rec_bank;
          r_bank       <= '0;
          r_acc        <= '0;
          r_wr_fired   <= 1'b0;
          busy         <= 1'b1;
          ram_a        <= {block, BANK_BITS'(0)};
        end
        S_DECIDE: begin
          r_wr      <= w_wr;
          r_cnt     <= '0;
          r_from_rd <= w_rd;
          if (w_wr) r_wr_fired <= 1'b1;
          if (w_rd) begin
            ram_cen <= 1'b0;
            ram_oen <= 1'b0;
          end else if (w_wr) begin
            ram_cen <= 1'b0;
            ram_wen <= 1'b0;
          end
        end
        S_READ: begin
          if (w_last) begin
            r_acc   <= r_acc + {{BANK_BITS{ram_dq_o[DATA_W-1]}}, ram_dq_o};
            ram_cen <= 1'b1;
            ram_oen <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_WRITE: begin
          if (w_last) begin
            ram_cen <= 1'b1;
            ram_wen <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RECOV: begin
          r_cnt     <= '0;
          r_from_rd <= 1'b0;
          if (r_from_rd && r_wr) begin
            ram_cen <= 1'b0;
            ram_wen <= 1'b0;
          end
        end
        S_NEXT: if (r_bank != BANK_BITS'(NBANKS - 1)) begin
          r_bank <= w_bank_inc;
          ram_a  <= {block, w_bank_inc};
        end
        S_FINISH: begin
          mix_out   <= r_acc;
          mix_valid <= 1'b1;
          busy      <= 1'b0;
          del_ack   <= r_del_pend;
          active    <= w_active_nxt;
          if (w_active_nxt == '0) begin
            // Nothing left to play: loop length is forgotten.
            max_block  <= '0;
            block      <= '0;
            r_rec_seen <= 1'b0;
          end else if (max_block != '0) begin
            block <= (w_blk_inc == max_block) ? '0 : w_blk_inc;
          end else if (r_rec_en_l) begin
            // Length still open: grow one block per recorded sweep, and
            // close the loop at the counter limit.
            if (w_blk_inc == BLK_MAX) begin
              max_block  <= BLK_MAX;
              block      <= '0;
              r_rec_seen <= 1'b0;
            end else begin
              block      <= w_blk_inc;
              r_rec_seen <= 1'b1;
            end
          end else if (r_rec_seen) begin
            // First sweep after the recording stopped fixes the length.
            max_block  <= block;
            block      <= '0;
            r_rec_seen <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_loop_bank_sequencer.sv
// Bench for loop_bank_sequencer: 8 banks, 4-bit block counter, 4-cycle
// accesses. A behavioural RAM answers the strobes; a monitor checks strobe
// width, address setup and mix results popped from a scoreboard queue.
module tb_loop_bank_sequencer;

  localparam int NB = 8, BB = 3, BW = 4, DW = 32, AC = 4;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            sample_tick = 1'b0;
  logic [DW-1:0]   sample_in = '0;
  logic            play_en = 1'b0, rec_en = 1'b0, del_req = 1'b0;
  logic [BB-1:0]   rec_bank = '0, del_bank = '0;
  logic            del_ack, ram_cen, ram_oen, ram_wen, mix_valid, busy, overrun;
  logic [BB+BW-1:0] ram_a;
  logic [DW-1:0]   ram_dq_i, ram_dq_o;
  logic [DW+BB-1:0] mix_out;
  logic [NB-1:0]   active;
  logic [BW-1:0]   block, max_block;

  always #5 clk = ~clk;

  loop_bank_sequencer #(.NBANKS(NB), .BANK_BITS(BB), .BLOCK_W(BW),
                        .DATA_W(DW), .ACC_CYC(AC)) dut (
    .clk_100MHz(clk), .rstn(rstn), .sample_tick(sample_tick),
    .sample_in(sample_in), .play_en(play_en), .rec_en(rec_en),
    .rec_bank(rec_bank), .del_req(del_req), .del_bank(del_bank),
    .del_ack(del_ack), .ram_a(ram_a), .ram_dq_i(ram_dq_i),
    .ram_dq_o(ram_dq_o), .ram_cen(ram_cen), .ram_oen(ram_oen),
    .ram_wen(ram_wen), .mix_out(mix_out), .mix_valid(mix_valid),
    .active(active), .block(block), .max_block(max_block),
    .busy(busy), .overrun(overrun));

  // Behavioural RAM
  logic [DW-1:0] mem [0:(1<<(BB+BW))-1];
  initial for (int i = 0; i < (1<<(BB+BW)); i++) mem[i] = '0;
  assign ram_dq_o = (!ram_cen && !ram_oen) ? mem[ram_a] : '0;
  always @(posedge clk) if (rstn && !ram_cen && !ram_wen) mem[ram_a] <= ram_dq_i;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  typedef struct { logic [DW+BB-1:0] mix; logic del; } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic play, rec; logic [BB-1:0] rb; logic [DW-1:0] smp;
    logic del; logic [BB-1:0] db;
    logic [DW+BB-1:0] mix; logic [NB-1:0] act; logic [BW-1:0] blk, mx;
    int nacc; int wa;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mk(logic p, logic r, logic [BB-1:0] rb, logic [DW-1:0] s,
                              logic d, logic [BB-1:0] db, logic [DW+BB-1:0] m,
                              logic [NB-1:0] a, logic [BW-1:0] b, logic [BW-1:0] mx,
                              int n, int w);
    vec_t v;
    v.play = p; v.rec = r; v.rb = rb; v.smp = s; v.del = d; v.db = db;
    v.mix = m; v.act = a; v.blk = b; v.mx = mx; v.nacc = n; v.wa = w;
    return v;
  endfunction

  // Monitor: access count, write addresses, strobe width, address setup,
  // mix scoreboard.
  int n_acc = 0, mv_cnt = 0, low_cnt = 0;
  int wq[$];
  logic prev_cen = 1'b1;
  logic [BB+BW-1:0] prev_a = '0;
  always @(negedge clk) begin
    if (!rstn) begin
      low_cnt = 0; prev_cen = 1'b1;
    end else begin
      if (prev_cen && !ram_cen) begin
        n_acc++;
        chk("addr_setup", 64'(ram_a), 64'(prev_a));
        if (!ram_wen) wq.push_back(int'(ram_a));
      end
      if (!ram_cen) low_cnt++;
      else if (low_cnt != 0) begin
        chk("strobe_len", 64'(low_cnt), 64'(AC));
        low_cnt = 0;
      end
      if (mix_valid) begin
        sb_t e;
        mv_cnt++;
        chk("sb_pending", 64'(sbq.size() != 0), 64'd1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("mix_out", 64'(mix_out), 64'(e.mix));
          chk("del_ack", 64'(del_ack), 64'(e.del));
          chk("busy_fall", 64'(busy), 64'd0);
        end
      end
      prev_cen = ram_cen; prev_a = ram_a;
    end
  end

  task automatic wait_idle();
    int c = 0;
    while (busy && c < 2000) begin @(negedge clk); c++; end
    chk("sweep_timeout", 64'(busy), 64'd0);
    @(negedge clk);
  endtask

  task automatic start_tick(input vec_t v);
    @(negedge clk);
    n_acc = 0; wq.delete(); mv_cnt = 0;
    play_en = v.play; rec_en = v.rec; rec_bank = v.rb; sample_in = v.smp;
    del_req = v.del; del_bank = v.db; sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0; del_req = 1'b0;
    chk("busy_rise", 64'(busy), 64'd1);
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int got_wa;
    sbq.push_back('{v.mix, v.del});
    start_tick(v);
    wait_idle();
    got_wa = (wq.size() == 0) ? -1 : (wq.size() == 1) ? wq[0] : -2;
    chk({nm, "_active"}, 64'(active), 64'(v.act));
    chk({nm, "_block"},  64'(block), 64'(v.blk));
    chk({nm, "_maxblk"}, 64'(max_block), 64'(v.mx));
    chk({nm, "_naccess"}, 64'(n_acc), 64'(v.nacc));
    chk({nm, "_wraddr"}, 64'(got_wa), 64'(v.wa));
    chk({nm, "_mvpulse"}, 64'(mv_cnt), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    // Record bank 2 for 5 sweeps, then stop: length 5.
    for (int i = 0; i < 5; i++)
      vt.push_back(mk(0,1,2,32'h100+i,0,0,0,8'h04,BW'(i+1),0,1,i*8+2));
    vt.push_back(mk(0,0,0,0,0,0,0,8'h04,0,5,0,-1));
    // Fill banks 1 and 3 over the defined loop.
    for (int i = 0; i < 5; i++)
      vt.push_back(mk(0,1,1,32'h10,0,0,0,8'h06,BW'((i+1)%5),5,1,i*8+1));
    for (int i = 0; i < 5; i++)
      vt.push_back(mk(0,1,3,32'hFFFF_FFF0,0,0,0,8'h0E,BW'((i+1)%5),5,1,i*8+3));
    // Play all three while deleting bank 2, then banks 1+3 cancel out.
    vt.push_back(mk(1,0,0,0,1,2,35'h100,8'h0A,1,5,3,-1));
    for (int i = 1; i < 5; i++)
      vt.push_back(mk(1,0,0,0,0,0,0,8'h0A,BW'((i+1)%5),5,2,-1));
    // Overdub bank 1 while playing: read old, then write.
    vt.push_back(mk(1,1,1,32'h20,0,0,0,8'h0A,1,5,3,1));
    // Delete bank 1, then delete the last bank while recording it.
    vt.push_back(mk(0,0,0,0,1,1,0,8'h08,2,5,0,-1));
    vt.push_back(mk(0,1,3,32'h5,1,3,0,8'h00,0,0,0,-1));

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_strobes", 64'({ram_cen, ram_oen, ram_wen}), 64'b111);
    chk("rst_addr_data", 64'({ram_a, ram_dq_i}), 64'd0);
    chk("rst_mix", 64'({mix_out, mix_valid, del_ack}), 64'd0);
    chk("rst_status", 64'({busy, overrun, active, block, max_block}), 64'd0);
    rstn = 1'b1;

    for (int i = 0; i < vt.size(); i++) run_vec($sformatf("vec%0d", i), vt[i]);
    chk("overdub_data", 64'(mem[1]), 64'h20);

    // Reset in the middle of a read.
    run_vec("pre_rst", mk(0,1,0,32'h55,0,0,0,8'h01,1,0,1,0));
    start_tick(mk(1,0,0,0,0,0,0,0,0,0,0,0));
    begin
      int c = 0;
      while (ram_oen && c < 200) begin @(negedge clk); c++; end
      chk("read_seen", 64'(ram_oen), 64'd0);
    end
    #2 rstn = 1'b0;
    #1;
    chk("midrst_strobes", 64'({ram_cen, ram_oen, ram_wen}), 64'b111);
    chk("midrst_status", 64'({busy, active, block, max_block, mix_valid}), 64'd0);
    chk("midrst_addr", 64'({ram_a, mix_out}), 64'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    run_vec("post_rst", mk(0,1,0,32'h77,0,0,0,8'h01,1,0,1,0));

    // Length left open until the block counter limit.
    for (int i = 1; i < 15; i++) begin
      v = mk(0,1,0,i,0,0,0,8'h01, (i == 14) ? BW'(0) : BW'(i+1),
             (i == 14) ? BW'(15) : BW'(0), 1, i*8);
      run_vec($sformatf("wrap%0d", i), v);
    end

    // Tick while busy.
    sbq.push_back('{'0, 1'b0});
    start_tick(mk(0,0,0,0,0,0,0,0,0,0,0,0));
    repeat (8) @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    chk("overrun_set", 64'(overrun), 64'd1);
    wait_idle();
    chk("overrun_mv", 64'(mv_cnt), 64'd1);
    chk("overrun_block", 64'(block), 64'd1);
    run_vec("after_ovr", mk(0,0,0,0,0,0,0,8'h01,2,15,0,-1));
    chk("overrun_sticky", 64'(overrun), 64'd1);
    chk("sb_drained", 64'(sbq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
